// File: rtl/gcd_pkg.sv
// Shared types and width helpers for the binary (Stein) GCD engine.
package gcd_pkg;

  localparam int GCD_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    REDUCE,
    DONE
  } state_e;

  // One datapath operation per cycle, chosen by the controller.
  typedef enum logic [3:0] {
    DP_HOLD,
    DP_LOAD,
    DP_LOAD_ZERO,
    DP_HALVE_BOTH,
    DP_HALVE_A,
    DP_HALVE_B,
    DP_SUB_A,
    DP_SUB_B,
    DP_FINISH
  } dp_op_e;

  function automatic int gcd_k_width(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic int gcd_iter_width(input int width);
    return $clog2(2 * width + 2);
  endfunction

endpackage

// File: rtl/gcd_stein_ctrl.sv
// FSM and handshake control for gcd_stein; turns datapath status bits into one op per cycle.
module gcd_stein_ctrl
  import gcd_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   in_valid_i,
  input  logic   out_ready_i,
  input  logic   zero_in_i,
  input  logic   a_even_i,
  input  logic   b_even_i,
  input  logic   a_eq_b_i,
  input  logic   a_gt_b_i,
  output logic   in_ready_o,
  output logic   out_valid_o,
  output dp_op_e dp_op_o
);

  state_e state_q;
  state_e state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dp_op_o = DP_HOLD;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          if (zero_in_i) begin
            dp_op_o = DP_LOAD_ZERO;
            state_d = DONE;
          end else begin
            dp_op_o = DP_LOAD;
            state_d = REDUCE;
          end
        end
      end
      REDUCE: begin
        // Priority order matters: common factors of two are stripped before any subtract.
        if (a_even_i && b_even_i) begin
          dp_op_o = DP_HALVE_BOTH;
        end else if (a_even_i) begin
          dp_op_o = DP_HALVE_A;
        end else if (b_even_i) begin
          dp_op_o = DP_HALVE_B;
        end else if (a_eq_b_i) begin
          dp_op_o = DP_FINISH;
          state_d = DONE;
        end else if (a_gt_b_i) begin
          dp_op_o = DP_SUB_A;
        end else begin
          dp_op_o = DP_SUB_B;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready_o  = (state_q == IDLE) && !rst;
  assign out_valid_o = (state_q == DONE);

endmodule

// File: rtl/gcd_stein.sv
// Handshaked binary GCD engine: a/b/k/result datapath around gcd_stein_ctrl.
// Optional iteration counter port out_iter is enabled by defining GCD_ITER_CNT_EN.
module gcd_stein
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd
`ifdef GCD_ITER_CNT_EN
  ,
  output logic [gcd_iter_width(WIDTH)-1:0] out_iter
`endif
);

  localparam int KW = gcd_k_width(WIDTH);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] result_q, result_d;
  dp_op_e           dp_op;

  gcd_stein_ctrl u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .out_ready_i (out_ready),
    .zero_in_i   ((in_a == '0) || (in_b == '0)),
    .a_even_i    (!a_q[0]),
    .b_even_i    (!b_q[0]),
    .a_eq_b_i    (a_q == b_q),
    .a_gt_b_i    (a_q > b_q),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .dp_op_o     (dp_op)
  );

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    k_d      = k_q;
    result_d = result_q;
    case (dp_op)
      DP_LOAD: begin
        a_d = in_a;
        b_d = in_b;
        k_d = '0;
      end
      DP_LOAD_ZERO: begin
        a_d      = in_a;
        b_d      = in_b;
        k_d      = '0;
        result_d = in_a | in_b;
      end
      DP_HALVE_BOTH: begin
        a_d = a_q >> 1;
        b_d = b_q >> 1;
        k_d = k_q + KW'(1);
      end
      DP_HALVE_A: a_d = a_q >> 1;
      DP_HALVE_B: b_d = b_q >> 1;
      // Both operands are odd here, so the difference is even and the shift is exact.
      DP_SUB_A:   a_d = (a_q - b_q) >> 1;
      DP_SUB_B:   b_d = (b_q - a_q) >> 1;
      DP_FINISH:  result_d = a_q << k_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      k_q      <= '0;
      result_q <= '0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      k_q      <= k_d;
      result_q <= result_d;
    end
  end

  assign out_gcd = result_q;

`ifdef GCD_ITER_CNT_EN
  logic [gcd_iter_width(WIDTH)-1:0] iter_q, iter_d;

  always_comb begin
    iter_d = iter_q;
    case (dp_op)
      DP_LOAD, DP_LOAD_ZERO: iter_d = '0;
      DP_HOLD:               iter_d = iter_q;
      default:               iter_d = iter_q + 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iter_q <= '0;
    end else begin
      iter_q <= iter_d;
    end
  end

  assign out_iter = iter_q;
`endif

endmodule

// File: tb/tb_gcd_stein.sv
// Randomised and directed bench for gcd_stein at WIDTH=16, 8 and 32 against a Euclid reference model.
module tb_gcd_stein;
  import gcd_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        iv   [3];
  logic        ordy [3];
  logic [31:0] a_s  [3];
  logic [31:0] b_s  [3];

  wire        rdy16, ov16, rdy8, ov8, rdy32, ov32;
  wire [15:0] g16;
  wire [7:0]  g8;
  wire [31:0] g32;
`ifdef GCD_ITER_CNT_EN
  wire [gcd_iter_width(16)-1:0] it16;
  wire [gcd_iter_width(8)-1:0]  it8;
  wire [gcd_iter_width(32)-1:0] it32;
`endif

  gcd_stein #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(rdy16),
    .in_a(a_s[0][15:0]), .in_b(b_s[0][15:0]),
    .out_valid(ov16), .out_ready(ordy[0]), .out_gcd(g16)
`ifdef GCD_ITER_CNT_EN
    , .out_iter(it16)
`endif
  );

  gcd_stein #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(rdy8),
    .in_a(a_s[1][7:0]), .in_b(b_s[1][7:0]),
    .out_valid(ov8), .out_ready(ordy[1]), .out_gcd(g8)
`ifdef GCD_ITER_CNT_EN
    , .out_iter(it8)
`endif
  );

  gcd_stein #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(rdy32),
    .in_a(a_s[2]), .in_b(b_s[2]),
    .out_valid(ov32), .out_ready(ordy[2]), .out_gcd(g32)
`ifdef GCD_ITER_CNT_EN
    , .out_iter(it32)
`endif
  );

  logic        rdy_s [3];
  logic        ov_s  [3];
  logic [31:0] g_s   [3];
  logic [31:0] it_s  [3];

  always_comb begin
    rdy_s[0] = rdy16; rdy_s[1] = rdy8; rdy_s[2] = rdy32;
    ov_s[0]  = ov16;  ov_s[1]  = ov8;  ov_s[2]  = ov32;
    g_s[0]   = 32'(g16); g_s[1] = 32'(g8); g_s[2] = g32;
    it_s[0]  = 32'd0; it_s[1] = 32'd0; it_s[2] = 32'd0;
`ifdef GCD_ITER_CNT_EN
    it_s[0]  = 32'(it16); it_s[1] = 32'(it8); it_s[2] = 32'(it32);
`endif
  end

  int checks   = 0;
  int failures = 0;

  // Scoreboard state per channel: expected result and measured REDUCE count.
  logic [31:0] exp_g   [3];
  logic        busy    [3];
  int          n_meas  [3];
  logic        n_known [3];

  function automatic int wid(input int c);
    return (c == 0) ? 16 : (c == 1) ? 8 : 32;
  endfunction

  function automatic logic [31:0] mask(input int c);
    return (wid(c) == 32) ? 32'hFFFF_FFFF : ((32'h1 << wid(c)) - 32'h1);
  endfunction

  // Euclid with remainder: deliberately a different algorithm from the engine.
  function automatic logic [31:0] ref_gcd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic chk_le(input string name, input int act, input int lim);
    checks++;
    if (act > lim) begin
      failures++;
      $display("FAIL %s actual=%0d required<=%0d", name, act, lim);
    end
  endtask

  // Compare process: every cycle a result is presented it must match the model.
  always @(negedge clk) begin
    for (int c = 0; c < 3; c++) begin
      if (!rst && ov_s[c]) begin
        if (busy[c]) begin
          chk($sformatf("gcd_w%0d", wid(c)), g_s[c], exp_g[c]);
`ifdef GCD_ITER_CNT_EN
          if (n_known[c]) chk($sformatf("iter_w%0d", wid(c)), it_s[c], 32'(n_meas[c]));
`endif
        end else begin
          chk($sformatf("spurious_valid_w%0d", wid(c)), 32'(ov_s[c]), 32'd0);
        end
      end
    end
  end

  task automatic xfer(input int c, input logic [31:0] a, input logic [31:0] b,
                      input int stall, output int n, output logic [31:0] g);
    int t;
    t = 0;
    @(negedge clk);
    while (!rdy_s[c] && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!rdy_s[c]) chk("ready_timeout", 32'(rdy_s[c]), 32'd1);
    a_s[c]  = a;
    b_s[c]  = b;
    iv[c]   = 1'b1;
    ordy[c] = (stall == 0);
    @(posedge clk);
    exp_g[c]   = ref_gcd(a & mask(c), b & mask(c));
    busy[c]    = 1'b1;
    n_known[c] = 1'b0;
    #1;
    iv[c]  = 1'b0;
    a_s[c] = $urandom;
    b_s[c] = $urandom;
    t = 1;
    while (!ov_s[c] && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!ov_s[c]) chk("valid_timeout", 32'(ov_s[c]), 32'd1);
    n          = t - 1;
    n_meas[c]  = n;
    n_known[c] = 1'b1;
    g          = g_s[c];
    chk_le($sformatf("n_bound_w%0d", wid(c)), n, 2 * wid(c) + 1);
    if (stall > 0) begin
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        chk("stall_in_ready", 32'(rdy_s[c]), 32'd0);
        chk("stall_valid", 32'(ov_s[c]), 32'd1);
        if (s == 2) begin
          a_s[c] = 32'd100;
          b_s[c] = 32'd75;
          iv[c]  = 1'b1;
        end
      end
      @(negedge clk);
      iv[c]   = 1'b0;
      ordy[c] = 1'b1;
    end
    @(posedge clk);
    #1;
    busy[c] = 1'b0;
    chk("hs_valid_low", 32'(ov_s[c]), 32'd0);
    chk("hs_in_ready", 32'(rdy_s[c]), 32'd1);
    ordy[c] = 1'b0;
  endtask

  function automatic logic [31:0] rnd(input int c);
    logic [31:0] v;
    v = $urandom;
    if ($urandom_range(0, 15) == 0) v = 32'd0;
    else if ($urandom_range(0, 7) == 0) v = v & 32'hFF;
    return v & mask(c);
  endfunction

  task automatic sweep(input int c);
    int n, stall;
    logic [31:0] g;
    for (int i = 0; i < 1000; i++) begin
      stall = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      xfer(c, rnd(c), rnd(c), stall, n, g);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] g;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      iv[c] = 1'b0; ordy[c] = 1'b0; a_s[c] = '0; b_s[c] = '0;
      exp_g[c] = '0; busy[c] = 1'b0; n_meas[c] = 0; n_known[c] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(rdy_s[0]), 32'd0);
    chk("rst_out_valid", 32'(ov_s[0]), 32'd0);
    chk("rst_out_gcd", g_s[0], 32'd0);
    chk("rst_out_iter", it_s[0], 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", 32'(rdy_s[0]), 32'd1);

    chk("ref_1500_192", ref_gcd(32'd1500, 32'd192), 32'd12);
    chk("ref_48_18", ref_gcd(32'd48, 32'd18), 32'd6);
    chk("ref_0_0", ref_gcd(32'd0, 32'd0), 32'd0);

    xfer(0, 32'd1500, 32'd192, 0, n, g);
    chk("n_1500_192", 32'(n), 32'd13);
    chk("g_1500_192", g, 32'd12);
    xfer(0, 32'd7, 32'd7, 0, n, g);
    chk("n_7_7", 32'(n), 32'd1);
    chk("g_7_7", g, 32'd7);
    xfer(0, 32'd0, 32'd45, 0, n, g);
    chk("n_0_45", 32'(n), 32'd0);
    chk("g_0_45", g, 32'd45);
    xfer(0, 32'd0, 32'd0, 0, n, g);
    chk("n_0_0", 32'(n), 32'd0);
    chk("g_0_0", g, 32'd0);
    xfer(0, 32'd48, 32'd18, 10, n, g);
    chk("n_48_18", 32'(n), 32'd6);
    chk("g_48_18", g, 32'd6);

    // Reset during REDUCE: the in-flight result must never appear.
    @(negedge clk);
    a_s[0] = 32'd1500; b_s[0] = 32'd192; iv[0] = 1'b1; ordy[0] = 1'b1;
    @(posedge clk);
    #1 iv[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", 32'(ov_s[0]), 32'd0);
    chk("midrst_in_ready_in_rst", 32'(rdy_s[0]), 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(rdy_s[0]), 32'd1);
    ordy[0] = 1'b0;
    xfer(0, 32'd35, 32'd21, 0, n, g);
    chk("n_35_21", 32'(n), 32'd3);
    chk("g_35_21", g, 32'd7);

    fork
      sweep(1);
      sweep(2);
    join

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
